// File: rtl/proc_io_pkg.sv
// Shared sizing helpers and limits for the processor I/O hub.
package proc_io_pkg;

  localparam int unsigned FDEPTH_MIN = 2;
  localparam int unsigned FDEPTH_MAX = 64;
  localparam int unsigned NCH_MIN    = 1;
  localparam int unsigned NCH_MAX    = 16;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Channel index width; a single channel still gets a 1-bit address.
  function automatic int unsigned addr_width(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  localparam int unsigned AIW_DEF = addr_width(5);
  localparam int unsigned AOW_DEF = addr_width(6);

endpackage

// File: rtl/io_fifo.sv
// Register-based output FIFO; head word is always visible on dout.
module io_fifo
  import proc_io_pkg::*;
#(
  parameter int unsigned NBITS  = 32,
  parameter int unsigned FDEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [NBITS-1:0] din,
  input  logic             rdy,
  output logic [NBITS-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = clog2(FDEPTH);
  localparam int unsigned CW = PW + 1;

  logic [NBITS-1:0] mem [FDEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(FDEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = rdy & ~empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  // Pointers wrap naturally since FDEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/proc_io_hub.sv
// Processor-side I/O hub: stalling reads from valid-flagged input words,
// buffered writes into per-channel output FIFOs.
module proc_io_hub
  import proc_io_pkg::*;
#(
  parameter int unsigned NBITS  = 32,
  parameter int unsigned NUIOIN = 5,
  parameter int unsigned NUIOOU = 6,
  parameter int unsigned FDEPTH = 4,
  localparam int unsigned AIW   = addr_width(NUIOIN),
  localparam int unsigned AOW   = addr_width(NUIOOU)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     proc_req_in,
  input  logic [AIW-1:0]           addr_in,
  output logic [NBITS-1:0]         proc_din,
  input  logic                     proc_out_en,
  input  logic [AOW-1:0]           addr_out,
  input  logic [NBITS-1:0]         proc_dout,
  output logic                     stall,
  input  logic [NUIOIN*NBITS-1:0]  io_in,
  input  logic [NUIOIN-1:0]        in_vld,
  output logic [NUIOIN-1:0]        req_in,
  output logic [NUIOOU*NBITS-1:0]  io_out,
  output logic [NUIOOU-1:0]        out_en,
  input  logic [NUIOOU-1:0]        out_rdy,
  output logic                     err_addr
);

  localparam logic [AIW:0] NIN_L = (AIW + 1)'(NUIOIN);
  localparam logic [AOW:0] NOU_L = (AOW + 1)'(NUIOOU);

  logic              in_ok;
  logic              out_ok;
  logic              sel_vld;
  logic              sel_full;
  logic [NBITS-1:0]  sel_word;
  logic              rd_stall;
  logic              wr_stall;
  logic              rd_acc;
  logic              wr_acc;
  logic              err_hit;
  logic [NUIOOU-1:0] full;
  logic [NUIOOU-1:0] empty;
  logic [NUIOOU-1:0] push;

  assign in_ok  = ({1'b0, addr_in}  < NIN_L);
  assign out_ok = ({1'b0, addr_out} < NOU_L);

  // Out-of-range addresses match no channel, so their selections stay 0.
  always_comb begin
    sel_vld  = 1'b0;
    sel_word = '0;
    for (int unsigned i = 0; i < NUIOIN; i++) begin
      if (addr_in == AIW'(i)) begin
        sel_vld  = in_vld[i];
        sel_word = io_in[i*NBITS +: NBITS];
      end
    end
  end

  always_comb begin
    sel_full = 1'b0;
    for (int unsigned i = 0; i < NUIOOU; i++) begin
      if (addr_out == AOW'(i)) sel_full = full[i];
    end
  end

  assign rd_stall = proc_req_in & in_ok & ~sel_vld;
  assign wr_stall = proc_out_en & out_ok & sel_full;
  assign stall    = rd_stall | wr_stall;
  assign rd_acc   = proc_req_in & in_ok & sel_vld & ~stall & ~rst;
  assign wr_acc   = proc_out_en & out_ok & ~stall & ~rst;
  assign err_hit  = (proc_req_in & ~in_ok) | (proc_out_en & ~out_ok);

  always_comb begin
    req_in = '0;
    push   = '0;
    for (int unsigned i = 0; i < NUIOIN; i++) begin
      if (rd_acc && addr_in == AIW'(i)) req_in[i] = 1'b1;
    end
    for (int unsigned i = 0; i < NUIOOU; i++) begin
      if (wr_acc && addr_out == AOW'(i)) push[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proc_din <= '0;
      err_addr <= 1'b0;
    end else begin
      if (rd_acc)  proc_din <= sel_word;
      if (err_hit) err_addr <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUIOOU; g++) begin : g_ch
    io_fifo #(
      .NBITS  (NBITS),
      .FDEPTH (FDEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[g]),
      .din   (proc_dout),
      .rdy   (out_rdy[g]),
      .dout  (io_out[g*NBITS +: NBITS]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  assign out_en = ~empty;

endmodule

// File: tb/tb_proc_io_hub.sv
// Self-checking bench for proc_io_hub: vector table plus directed corner sequences.
module tb_proc_io_hub;

  localparam int NI = 5;
  localparam int NO = 6;
  localparam int NB = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           proc_req_in;
  logic [2:0]     addr_in;
  logic [NB-1:0]  proc_din;
  logic           proc_out_en;
  logic [2:0]     addr_out;
  logic [NB-1:0]  proc_dout;
  logic           stall;
  logic [NI*NB-1:0] io_in;
  logic [NI-1:0]  in_vld;
  logic [NI-1:0]  req_in;
  logic [NO*NB-1:0] io_out;
  logic [NO-1:0]  out_en;
  logic [NO-1:0]  out_rdy;
  logic           err_addr;

  proc_io_hub #(
    .NBITS  (NB),
    .NUIOIN (NI),
    .NUIOOU (NO),
    .FDEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .proc_req_in (proc_req_in),
    .addr_in     (addr_in),
    .proc_din    (proc_din),
    .proc_out_en (proc_out_en),
    .addr_out    (addr_out),
    .proc_dout   (proc_dout),
    .stall       (stall),
    .io_in       (io_in),
    .in_vld      (in_vld),
    .req_in      (req_in),
    .io_out      (io_out),
    .out_en      (out_en),
    .out_rdy     (out_rdy),
    .err_addr    (err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rq;
    logic [2:0]  ai;
    logic [4:0]  vld;
    logic        we;
    logic [2:0]  ao;
    logic [31:0] d;
    logic        st;
    logic [4:0]  rq_exp;
  } vec_t;

  vec_t        tbl [11];
  logic [31:0] mq [NO][$];
  logic [31:0] exp_din;
  logic        exp_err;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs and FIFO heads,
  // advance the scoreboard, then check registered outputs after the edge.
  task automatic apply(input string nm, input logic rq, input logic [2:0] ai,
                       input logic [4:0] vld, input logic we, input logic [2:0] ao,
                       input logic [31:0] d, input logic [5:0] rdy,
                       input logic exp_stall, input logic [4:0] exp_req);
    logic [5:0]  exp_oe;
    logic [31:0] w;
    proc_req_in = rq;  addr_in  = ai;  in_vld    = vld;
    proc_out_en = we;  addr_out = ao;  proc_dout = d;  out_rdy = rdy;
    #1;
    check({nm, " stall"}, 32'(stall), 32'(exp_stall));
    check({nm, " req_in"}, 32'(req_in), 32'(exp_req));
    for (int c = 0; c < NO; c++) exp_oe[c] = (mq[c].size() != 0);
    check({nm, " out_en"}, 32'(out_en), 32'(exp_oe));
    for (int c = 0; c < NO; c++) begin
      if (rdy[c] && mq[c].size() != 0) begin
        w = mq[c].pop_front();
        check($sformatf("%s io_out%0d", nm, c), io_out[c*NB +: NB], w);
      end
    end
    if (we && ao < 3'(NO) && !exp_stall) mq[ao].push_back(d);
    if (exp_req != '0) exp_din = io_in[ai*NB +: NB];
    if ((rq && ai >= 3'(NI)) || (we && ao >= 3'(NO))) exp_err = 1'b1;
    @(posedge clk); #1;
    check({nm, " proc_din"}, proc_din, exp_din);
    check({nm, " err_addr"}, 32'(err_addr), 32'(exp_err));
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    #1;
    check({nm, " rst out_en"}, 32'(out_en), 32'd0);
    check({nm, " rst req_in"}, 32'(req_in), 32'd0);
    check({nm, " rst proc_din"}, proc_din, 32'd0);
    check({nm, " rst err_addr"}, 32'(err_addr), 32'd0);
    check({nm, " rst stall"}, 32'(stall), 32'd0);
    for (int c = 0; c < NO; c++) mq[c].delete();
    exp_din = '0;
    exp_err = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    proc_req_in = 1'b0; addr_in = '0; in_vld = '0;
    proc_out_en = 1'b0; addr_out = '0; proc_dout = '0; out_rdy = '1;
    for (int i = 0; i < NI; i++) io_in[i*NB +: NB] = 32'hC0DE0000 + 32'(i);
    io_in[2*NB +: NB] = 32'h3F800000;
    exp_din = '0;
    exp_err = 1'b0;
    @(posedge clk); #1;
    do_reset("init");

    tbl[0]  = '{1'b1, 3'd2, 5'b00100, 1'b0, 3'd0, 32'h0,        1'b0, 5'b00100};
    tbl[1]  = '{1'b1, 3'd0, 5'b00001, 1'b0, 3'd0, 32'h0,        1'b0, 5'b00001};
    tbl[2]  = '{1'b1, 3'd4, 5'b11111, 1'b0, 3'd0, 32'h0,        1'b0, 5'b10000};
    tbl[3]  = '{1'b1, 3'd3, 5'b10111, 1'b0, 3'd0, 32'h0,        1'b1, 5'b00000};
    tbl[4]  = '{1'b1, 3'd1, 5'b11111, 1'b1, 3'd0, 32'h11111111, 1'b0, 5'b00010};
    tbl[5]  = '{1'b1, 3'd1, 5'b00000, 1'b1, 3'd5, 32'h22222222, 1'b1, 5'b00000};
    tbl[6]  = '{1'b0, 3'd0, 5'b00000, 1'b1, 3'd5, 32'h22222222, 1'b0, 5'b00000};
    tbl[7]  = '{1'b0, 3'd0, 5'b00000, 1'b1, 3'd5, 32'h33333333, 1'b0, 5'b00000};
    tbl[8]  = '{1'b0, 3'd0, 5'b00000, 1'b1, 3'd4, 32'hDEADBEEF, 1'b0, 5'b00000};
    tbl[9]  = '{1'b0, 3'd0, 5'b00000, 1'b0, 3'd0, 32'h0,        1'b0, 5'b00000};
    tbl[10] = '{1'b0, 3'd0, 5'b00000, 1'b0, 3'd0, 32'h0,        1'b0, 5'b00000};
    for (int i = 0; i < 11; i++)
      apply($sformatf("v%0d", i), tbl[i].rq, tbl[i].ai, tbl[i].vld, tbl[i].we,
            tbl[i].ao, tbl[i].d, 6'h3F, tbl[i].st, tbl[i].rq_exp);

    // Read held against an invalid source, then released.
    for (int i = 0; i < 3; i++)
      apply($sformatf("rdwait%0d", i), 1, 3'd1, 5'b00000, 0, 3'd0, 0, 6'h3F, 1, 5'b00000);
    apply("rdgo", 1, 3'd1, 5'b00010, 0, 3'd0, 0, 6'h3F, 0, 5'b00010);

    // Fill ch3 with its sink blocked; the fifth write waits for one pop.
    for (int i = 1; i <= 4; i++)
      apply($sformatf("ch3w%0d", i), 0, 0, 0, 1, 3'd3, 32'hB0 + 32'(i), 6'b110111, 0, 0);
    apply("ch3w5full", 0, 0, 0, 1, 3'd3, 32'hB5, 6'b110111, 1, 0);
    apply("ch3w5pop",  0, 0, 0, 1, 3'd3, 32'hB5, 6'b111111, 1, 0);
    apply("ch3w5done", 0, 0, 0, 1, 3'd3, 32'hB5, 6'b110111, 0, 0);
    for (int i = 0; i < 5; i++)
      apply($sformatf("ch3drain%0d", i), 0, 0, 0, 0, 3'd0, 0, 6'h3F, 0, 0);

    // ch0: push+pop on full stalls; push+pop at count 2 holds count.
    for (int i = 1; i <= 4; i++)
      apply($sformatf("ch0w%0d", i), 0, 0, 0, 1, 3'd0, 32'hC0 + 32'(i), 6'b111110, 0, 0);
    apply("ch0fullpp", 0, 0, 0, 1, 3'd0, 32'hC5, 6'b111111, 1, 0);
    apply("ch0hold3",  0, 0, 0, 0, 3'd0, 0,      6'b111110, 0, 0);
    apply("ch0pop2",   0, 0, 0, 0, 3'd0, 0,      6'b111111, 0, 0);
    apply("ch0pp2",    0, 0, 0, 1, 3'd0, 32'hC6, 6'b111111, 0, 0);
    for (int i = 0; i < 3; i++)
      apply($sformatf("ch0drain%0d", i), 0, 0, 0, 0, 3'd0, 0, 6'h3F, 0, 0);

    // Out-of-range addresses: sticky error, no stall, no FIFO effect.
    apply("oorw",  0, 0, 0, 1, 3'd7, 32'h77777777, 6'h3F, 0, 0);
    apply("oori",  0, 0, 0, 0, 3'd0, 0, 6'h3F, 0, 0);
    apply("oorr",  1, 3'd6, 5'b11111, 0, 3'd0, 0, 6'h3F, 0, 0);
    do_reset("errclr");
    apply("post",  0, 0, 0, 0, 3'd0, 0, 6'h3F, 0, 0);

    // Reset mid-burst with two words queued on ch2.
    apply("rbw1", 0, 0, 0, 1, 3'd2, 32'hE1, 6'b111011, 0, 0);
    apply("rbw2", 0, 0, 0, 1, 3'd2, 32'hE2, 6'b111011, 0, 0);
    apply("rbrd", 1, 3'd0, 5'b11111, 0, 3'd0, 0, 6'b111011, 0, 5'b00001);
    proc_req_in = 1'b1; addr_in = 3'd0; in_vld = '1;
    proc_out_en = 1'b1; addr_out = 3'd2; proc_dout = 32'hE3; out_rdy = '1;
    #2;
    do_reset("midrst");
    for (int i = 0; i < 3; i++)
      apply($sformatf("afterrst%0d", i), 0, 0, 0, 0, 3'd0, 0, 6'h3F, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
